// File: rtl/i2c_csr_bridge_pkg.sv
// Shared definitions for the I2C-to-CSR bridge: bus widths, default target
// address, FSM state encoding and pointer arithmetic.
package i2c_csr_bridge_pkg;

  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;
  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h4a;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  // The register pointer wraps 31 -> 0 naturally in 5 bits.
  function automatic logic [CSR_AW-1:0] ptr_next(input logic [CSR_AW-1:0] p);
    return p + 5'd1;
  endfunction

endpackage

// File: rtl/i2c_csr_bridge_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the filtered value
// only follows the synchronised line after FILTER_LEN consecutive equal samples.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync;
  logic [2:0] cnt;

  // Synchronise, then count how long the synchronised value has disagreed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= 3'd0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= 3'd0;
      end else if (cnt == 3'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target front end: decodes filtered SCL/SDA into START/STOP/bit events
// and drives the shared 5-bit CSR bus with an auto-incrementing pointer.
module i2c_csr_bridge
  import i2c_csr_bridge_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = I2C_ADDR_DEFAULT,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [CSR_AW-1:0] csr_a,
  output logic [CSR_DW-1:0] csr_di,
  output logic              csr_we,
  input  logic [CSR_DW-1:0] csr_do,
  output logic              busy
);

  logic [1:0]        rst_pipe;
  logic              rst_i;
  logic              scl_f;
  logic              sda_f;
  logic              scl_d;
  logic              sda_d;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        rx_byte;
  logic              rw;
  logic              ack_on;
  logic              inc_pend;

  // Reset asserts immediately but is released in step with clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end
  assign rst_i = rst_pipe[1];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (clk),
    .rst  (rst_i),
    .raw  (scl),
    .filt (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (clk),
    .rst  (rst_i),
    .raw  (sda_in),
    .filt (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shreg[6:0], sda_f};

  // Protocol FSM; also owns the pointer, write strobe and SDA drive.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
      inc_pend <= 1'b0;
      sda_oe   <= 1'b0;
      csr_a    <= 5'd0;
      csr_di   <= 8'h00;
      csr_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_d  <= scl_f;
      sda_d  <= sda_f;
      csr_we <= 1'b0;
      if (inc_pend) begin
        csr_a    <= ptr_next(csr_a);
        inc_pend <= 1'b0;
      end
      if (stop_det) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
        ack_on  <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
        ack_on  <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                case (state)
                  ADDR: begin
                    if (rx_byte[7:1] == I2C_ADDR) begin
                      rw    <= rx_byte[0];
                      busy  <= 1'b1;
                      state <= ADDR_ACK;
                    end else begin
                      busy  <= 1'b0;
                      state <= IGNORE;
                    end
                  end
                  PTR: begin
                    csr_a <= rx_byte[4:0];
                    state <= PTR_ACK;
                  end
                  default: begin
                    csr_di   <= rx_byte;
                    csr_we   <= 1'b1;
                    inc_pend <= 1'b1;
                    state    <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First fall after the byte pulls SDA, the next one releases it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == ADDR_ACK && rw) begin
                  shreg  <= {csr_do[6:0], 1'b0};
                  sda_oe <= ~csr_do[7];
                  state  <= RDATA;
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RDATA_ACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          // The pointer advances even on NACK so the next read starts fresh.
          RDATA_ACK: begin
            if (scl_rise) begin
              csr_a <= ptr_next(csr_a);
              if (sda_f) begin
                busy  <= 1'b0;
                state <= IGNORE;
              end else begin
                ack_on <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on <= 1'b0;
              shreg  <= {csr_do[6:0], 1'b0};
              sda_oe <= ~csr_do[7];
              state  <= RDATA;
            end
          end
          default: begin
            bit_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Bench: bit-banged I2C master against the bridge, with write and read
// scoreboards fed at stimulus time and drained as the CSR bus responds.
module tb_i2c_csr_bridge;
  import i2c_csr_bridge_pkg::*;

  localparam int H = 16;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  wr_t        wq[$];
  logic [7:0] rq[$];

  function automatic logic [7:0] model_do(input logic [4:0] a);
    return 8'(a * 8'd13) + 8'h05;
  endfunction

  assign sda_line = sda_m & ~sda_oe;
  assign csr_do   = model_do(csr_a);

  always #5 clk = ~clk;

  i2c_csr_bridge dut (
    .clk    (clk),
    .rst    (rst),
    .scl    (scl_m),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write-strobe monitor drains the write scoreboard.
  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (csr_we === 1'b1) begin
      if (wq.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("we_addr", 32'(csr_a), 32'(e.a));
        check("we_data", 32'(csr_di), 32'(e.d));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    tick(H);
    scl_m = 1'b1;
    tick(H);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    tick(H);
    scl_m = 1'b1;
    tick(H / 2);
    @(negedge clk);
    b = sda_line;
    tick(H / 2);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    tick(H);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b0;
    tick(H);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    tick(H);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b1;
    tick(H);
  endtask

  // exp_line: 0 when the target should ACK, 1 when it should stay silent.
  task automatic send_byte(input logic [7:0] d, input string tag, input logic exp_line);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    check(tag, 32'(a), 32'(exp_line));
  endtask

  task automatic recv_byte(input logic master_nack);
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(master_nack);
    if (rq.size() == 0) begin
      check("rd_unexpected", 32'd1, 32'd0);
    end else begin
      e = rq.pop_front();
      check("rd_byte", 32'(d), 32'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, 32'(sda_oe), 32'd0);
    check({tag, "_a"}, 32'(csr_a), 32'd0);
    check({tag, "_di"}, 32'(csr_di), 32'd0);
    check({tag, "_we"}, 32'(csr_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int oe0;
    int busy0;
    logic [7:0] part;

    tick(4);
    rst = 1'b0;
    tick(6);
    @(negedge clk);
    check_reset_outputs("rst");
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Write two bytes from pointer 2.
    do_start();
    send_byte(8'h94, "wr_addr_ack", 1'b0);
    check("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h02, "wr_ptr_ack", 1'b0);
    wq.push_back('{a: 5'd2, d: 8'h3c});
    send_byte(8'h3c, "wr_d0_ack", 1'b0);
    wq.push_back('{a: 5'd3, d: 8'h5a});
    send_byte(8'h5a, "wr_d1_ack", 1'b0);
    do_stop();
    check("wr_final_a", 32'(csr_a), 32'd4);
    check("wr_busy_end", 32'(busy), 32'd0);

    // Repeated-start read across the 31 -> 0 wrap.
    do_start();
    send_byte(8'h94, "rd_addr_w_ack", 1'b0);
    send_byte(8'h1f, "rd_ptr_ack", 1'b0);
    do_start();
    send_byte(8'h95, "rd_addr_r_ack", 1'b0);
    rq.push_back(model_do(5'd31));
    recv_byte(1'b0);
    rq.push_back(model_do(5'd0));
    recv_byte(1'b1);
    do_stop();
    check("rd_final_a", 32'(csr_a), 32'd1);
    check("rd_busy_end", 32'(busy), 32'd0);

    // Wrong address: target stays off the bus.
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    do_start();
    send_byte(8'h96, "wa_addr_nack", 1'b1);
    send_byte(8'hff, "wa_data_nack", 1'b1);
    do_stop();
    check("wa_no_oe", 32'(oe_cnt - oe0), 32'd0);
    check("wa_no_busy", 32'(busy_cnt - busy0), 32'd0);

    // STOP after five data bits discards the partial byte.
    do_start();
    send_byte(8'h94, "ps_addr_ack", 1'b0);
    send_byte(8'h05, "ps_ptr_ack", 1'b0);
    part = 8'hb4;
    for (int i = 7; i >= 3; i--) send_bit(part[i]);
    do_stop();
    check("ps_a", 32'(csr_a), 32'd5);
    check("ps_state", 32'(dut.state), 32'(IDLE));

    // One-clock SDA glitch while SCL high must not look like START.
    @(posedge clk);
    sda_m = 1'b0;
    @(posedge clk);
    sda_m = 1'b1;
    tick(20);
    check("gl_state", 32'(dut.state), 32'(IDLE));

    // Reset in the middle of a data byte, then a normal write.
    do_start();
    send_byte(8'h94, "rm_addr_ack", 1'b0);
    send_byte(8'h06, "rm_ptr_ack", 1'b0);
    part = 8'h81;
    for (int i = 7; i >= 4; i--) send_bit(part[i]);
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(3);
    @(negedge clk);
    check_reset_outputs("rm");
    check("rm_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    tick(10);
    do_start();
    send_byte(8'h94, "rm2_addr_ack", 1'b0);
    send_byte(8'h07, "rm2_ptr_ack", 1'b0);
    wq.push_back('{a: 5'd7, d: 8'h81});
    send_byte(8'h81, "rm2_d_ack", 1'b0);
    do_stop();
    check("rm2_final_a", 32'(csr_a), 32'd8);

    tick(10);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
